// File: rtl/fe_ctrl.sv
// fe_ctrl: sequencing controller for the frequency-estimator datapath.
// Warm-up, block averaging, acquire/track lock loop and estimator watchdog.
module fe_ctrl #(
  parameter int NBW_FO   = 15,
  parameter int AVG_LOG2 = 2,
  parameter int NBW_TO   = 16,
  parameter int NBW_LAT  = 10
) (
  input  logic               clk,
  input  logic               rst_async,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_sub_en,
  input  logic [NBW_LAT-1:0] i_pipe_lat,
  input  logic [NBW_FO-1:0]  i_lock_thr,
  input  logic [NBW_TO-1:0]  i_timeout,
  input  logic               i_valid,
  output logic               o_fe_valid,
  output logic               o_fe_enable,
  output logic               o_fe_subsamp,
  output logic [NBW_LAT-1:0] o_fe_pipe_lat,
  input  logic               i_fo_valid,
  input  logic [NBW_FO-1:0]  i_fo_value,
  output logic               o_avg_valid,
  output logic [NBW_FO-1:0]  o_avg_value,
  output logic               o_locked,
  output logic               o_err,
  output logic [2:0]         o_state
);

  localparam int NBW_ACC = NBW_FO + AVG_LOG2;
  localparam logic [NBW_LAT:0]    WC_ONE  = 1;
  localparam logic [NBW_TO-1:0]   WD_ONE  = 1;
  localparam logic [AVG_LOG2-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WARM  = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t r_state, w_nxt;

  logic                       r_en, r_sub, r_locked, r_err;
  logic [NBW_LAT-1:0]         r_lat;
  logic [NBW_LAT:0]           r_wcnt;
  logic signed [NBW_ACC-1:0]  r_acc;
  logic [AVG_LOG2-1:0]        r_cnt;
  logic [NBW_FO-1:0]          r_avg, r_prev;
  logic                       r_avg_valid, r_has_prev, r_miss;
  logic [NBW_TO-1:0]          r_wd;

  logic                       w_run, w_keep, w_reacq, w_wd_fire, w_in_thr;
  logic signed [NBW_ACC-1:0]  w_sum;
  logic [NBW_FO-1:0]          w_avg;
  logic [NBW_FO:0]            w_diff, w_absd;
  logic [NBW_TO-1:0]          w_wd_inc;

  assign w_run    = (r_state == S_ACQ) || (r_state == S_TRACK);
  assign w_sum    = r_acc + {{AVG_LOG2{i_fo_value[NBW_FO-1]}}, i_fo_value};
  // floor(sum / 2**AVG_LOG2): the upper slice of the two's-complement sum
  assign w_avg    = w_sum[NBW_ACC-1:AVG_LOG2];
  assign w_diff   = {r_avg[NBW_FO-1], r_avg} - {r_prev[NBW_FO-1], r_prev};
  assign w_absd   = w_diff[NBW_FO] ? -w_diff : w_diff;
  assign w_in_thr = (w_absd <= {1'b0, i_lock_thr});
  assign w_wd_inc = r_wd + WD_ONE;
  assign w_wd_fire = w_run && (i_timeout != '0) && !i_fo_valid
                     && (w_wd_inc == i_timeout);
  // accumulator/lock history survive only while staying in ACQ/TRACK
  assign w_keep = w_run && !w_reacq
                  && ((w_nxt == S_ACQ) || (w_nxt == S_TRACK));

  // state register
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) r_state <= S_IDLE;
    else           r_state <= w_nxt;
  end

  // next state: stop > watchdog > lock decisions > start
  always_comb begin
    w_nxt   = r_state;
    w_reacq = 1'b0;
    if (i_stop) begin
      w_nxt = S_IDLE;
    end else if (w_wd_fire) begin
      w_nxt = S_ERR;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_nxt = S_WARM;
        S_WARM:  if (r_wcnt == '0) w_nxt = S_ACQ;
        S_ACQ:   if (r_avg_valid && r_has_prev && w_in_thr) w_nxt = S_TRACK;
        S_TRACK: begin
          if (r_avg_valid && !w_in_thr && r_miss) begin
            w_nxt   = S_ACQ;
            w_reacq = 1'b1;
          end
        end
        S_ERR:   w_nxt = S_ERR;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // registered control outputs decoded from the next state
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_en     <= 1'b0;
      r_sub    <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_en     <= (w_nxt == S_WARM) || (w_nxt == S_ACQ) || (w_nxt == S_TRACK);
      r_sub    <= (w_nxt == S_TRACK) && i_sub_en;
      r_locked <= (w_nxt == S_TRACK);
      r_err    <= (w_nxt == S_ERR);
    end
  end

  // pipeline latency capture and warm-up countdown
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_lat  <= '0;
      r_wcnt <= '0;
    end else if (r_state == S_IDLE && w_nxt == S_WARM) begin
      r_lat  <= i_pipe_lat;
      r_wcnt <= {1'b0, i_pipe_lat} + WC_ONE;
    end else if (r_state == S_WARM && r_wcnt != '0) begin
      r_wcnt <= r_wcnt - WC_ONE;
    end
  end

  // block accumulator and average output
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (!w_keep) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_fo_valid) begin
        if (r_cnt == '1) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_avg       <= w_avg;
          r_avg_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  // previous average and consecutive out-of-threshold tracking
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_prev     <= '0;
      r_has_prev <= 1'b0;
      r_miss     <= 1'b0;
    end else if (!w_keep) begin
      r_has_prev <= 1'b0;
      r_miss     <= 1'b0;
    end else if (r_avg_valid) begin
      r_prev     <= r_avg;
      r_has_prev <= 1'b1;
      r_miss     <= (r_state == S_TRACK) && !w_in_thr;
    end
  end

  // watchdog: cycles since last estimate while running
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)                   r_wd <= '0;
    else if (!w_keep || i_fo_valid)  r_wd <= '0;
    else                             r_wd <= w_wd_inc;
  end

  assign o_fe_enable   = r_en;
  assign o_fe_valid    = i_valid & r_en;
  assign o_fe_subsamp  = r_sub;
  assign o_fe_pipe_lat = r_lat;
  assign o_avg_valid   = r_avg_valid;
  assign o_avg_value   = r_avg;
  assign o_locked      = r_locked;
  assign o_err         = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_fe_ctrl.sv
// tb_fe_ctrl: scenario tasks for fe_ctrl with an averaging scoreboard.
// Expected block averages are queued at stimulus time and popped on o_avg_valid.
module tb_fe_ctrl;
  localparam int NBW_FO = 15;
  localparam int AVG_LOG2 = 2;
  localparam int NBW_TO = 16;
  localparam int NBW_LAT = 10;

  logic clk, rst_async, i_start, i_stop, i_sub_en, i_valid, i_fo_valid;
  logic [NBW_LAT-1:0] i_pipe_lat;
  logic [NBW_FO-1:0]  i_lock_thr, i_fo_value;
  logic [NBW_TO-1:0]  i_timeout;
  logic o_fe_valid, o_fe_enable, o_fe_subsamp, o_avg_valid, o_locked, o_err;
  logic [NBW_LAT-1:0] o_fe_pipe_lat;
  logic [NBW_FO-1:0]  o_avg_value;
  logic [2:0]         o_state;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int mon_exp;

  fe_ctrl #(.NBW_FO(NBW_FO), .AVG_LOG2(AVG_LOG2), .NBW_TO(NBW_TO),
            .NBW_LAT(NBW_LAT)) dut (
    .clk(clk), .rst_async(rst_async), .i_start(i_start), .i_stop(i_stop),
    .i_sub_en(i_sub_en), .i_pipe_lat(i_pipe_lat), .i_lock_thr(i_lock_thr),
    .i_timeout(i_timeout), .i_valid(i_valid), .o_fe_valid(o_fe_valid),
    .o_fe_enable(o_fe_enable), .o_fe_subsamp(o_fe_subsamp),
    .o_fe_pipe_lat(o_fe_pipe_lat), .i_fo_valid(i_fo_valid),
    .i_fo_value(i_fo_value), .o_avg_valid(o_avg_valid),
    .o_avg_value(o_avg_value), .o_locked(o_locked), .o_err(o_err),
    .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: every average pulse must match the queued value
  always @(negedge clk) begin
    if (!rst_async && o_avg_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL avg_unexpected got=%0d", $signed(o_avg_value));
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_avg_value !== NBW_FO'(mon_exp)) begin
          n_err++;
          $display("FAIL avg_value got=%0d exp=%0d",
                   $signed(o_avg_value), mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int floor_avg(input int s);
    return (s >= 0) ? s / 4 : (s - 3) / 4;
  endfunction

  task automatic clear_inputs();
    i_start = 0; i_stop = 0; i_sub_en = 0; i_valid = 0; i_fo_valid = 0;
    i_pipe_lat = '0; i_lock_thr = '0; i_timeout = '0; i_fo_value = '0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    rst_async = 1;
    #2;
    rst_async = 0;
  endtask

  task automatic send_valid(input int v);
    i_fo_valid = 1;
    i_fo_value = NBW_FO'(v);
    tick();
    i_fo_valid = 0;
    tick();
  endtask

  task automatic send_block(input int a, input int b, input int c, input int d);
    send_valid(a);
    send_valid(b);
    send_valid(c);
    exp_q.push_back(floor_avg(a + b + c + d));
    send_valid(d);
  endtask

  task automatic wait_acq(input int maxc);
    int n = 0;
    while (o_state !== 3'd2 && n < maxc) begin
      tick();
      n++;
    end
    n_vec++;
    if (o_state !== 3'd2) begin
      n_err++;
      $display("FAIL wait_acq timeout state=%0d exp=2", o_state);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_async = 1;
    #12;
    n_vec++;
    if ({o_state, o_fe_enable, o_fe_subsamp, o_locked, o_err, o_avg_valid,
         o_fe_valid} !== '0 || o_fe_pipe_lat !== '0 || o_avg_value !== '0) begin
      n_err++;
      $display("FAIL reset_outputs state=%0d en=%b avg=%0d lat=%0d exp=0",
               o_state, o_fe_enable, o_avg_value, o_fe_pipe_lat);
    end
    @(posedge clk);
    #2;
    rst_async = 0;
  endtask

  task automatic test_warm();
    int n;
    do_reset();
    i_lock_thr = 15'd4;
    i_sub_en = 1;
    i_valid = 1;
    tick();
    n_vec++;
    if (o_fe_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_fe_valid got=%b exp=0", o_fe_valid);
    end
    i_pipe_lat = 10'd5;
    i_start = 1;
    tick();
    i_start = 0;
    i_pipe_lat = 10'd9;
    i_fo_valid = 1;
    i_fo_value = 15'd999;
    n_vec++;
    if (o_state !== 3'd1 || o_fe_enable !== 1'b1 || o_fe_valid !== 1'b1) begin
      n_err++;
      $display("FAIL warm_entry state=%0d en=%b fv=%b exp=1/1/1",
               o_state, o_fe_enable, o_fe_valid);
    end
    n_vec++;
    if (o_fe_pipe_lat !== 10'd5) begin
      n_err++;
      $display("FAIL pipe_lat_latch got=%0d exp=5", o_fe_pipe_lat);
    end
    n = 0;
    while (o_state === 3'd1 && n < 100) begin
      n++;
      tick();
    end
    i_fo_valid = 0;
    i_valid = 0;
    n_vec++;
    if (n != 7) begin
      n_err++;
      $display("FAIL warm_cycles got=%0d exp=7", n);
    end
    n_vec++;
    if (o_state !== 3'd2 || o_fe_pipe_lat !== 10'd5) begin
      n_err++;
      $display("FAIL warm_exit state=%0d lat=%0d exp=2/5", o_state, o_fe_pipe_lat);
    end
  endtask

  task automatic test_average();
    send_block(100, 102, 98, 104);
    n_vec++;
    if (o_avg_value !== 15'd101) begin
      n_err++;
      $display("FAIL avg_hold got=%0d exp=101", $signed(o_avg_value));
    end
    send_block(-3, -4, -4, -4);
    n_vec++;
    if (o_state !== 3'd2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL avg_acq state=%0d pending=%0d exp=2/0", o_state, exp_q.size());
    end
  endtask

  task automatic test_lock();
    send_block(101, 101, 101, 101);
    n_vec++;
    if (o_state !== 3'd2) begin
      n_err++;
      $display("FAIL lock_far state=%0d exp=2", o_state);
    end
    send_block(102, 104, 103, 103);
    n_vec++;
    if (o_state !== 3'd3 || o_locked !== 1'b1 || o_fe_subsamp !== 1'b1) begin
      n_err++;
      $display("FAIL lock_enter state=%0d lk=%b ss=%b exp=3/1/1",
               o_state, o_locked, o_fe_subsamp);
    end
    i_sub_en = 0;
    tick();
    n_vec++;
    if (o_fe_subsamp !== 1'b0) begin
      n_err++;
      $display("FAIL subsamp_off got=%b exp=0", o_fe_subsamp);
    end
    i_sub_en = 1;
    tick();
    send_block(108, 112, 109, 111);
    n_vec++;
    if (o_state !== 3'd3) begin
      n_err++;
      $display("FAIL miss_one state=%0d exp=3", o_state);
    end
    send_block(120, 120, 120, 120);
    n_vec++;
    if (o_state !== 3'd2 || o_locked !== 1'b0 || o_fe_subsamp !== 1'b0) begin
      n_err++;
      $display("FAIL miss_two state=%0d lk=%b ss=%b exp=2/0/0",
               o_state, o_locked, o_fe_subsamp);
    end
    send_block(100, 100, 100, 100);
    n_vec++;
    if (o_state !== 3'd2) begin
      n_err++;
      $display("FAIL reacq_noprev state=%0d exp=2", o_state);
    end
    send_block(101, 101, 101, 101);
    send_block(110, 110, 110, 110);
    send_block(111, 111, 111, 111);
    n_vec++;
    if (o_state !== 3'd3 || o_locked !== 1'b1) begin
      n_err++;
      $display("FAIL miss_reset state=%0d lk=%b exp=3/1", o_state, o_locked);
    end
  endtask

  task automatic test_reset_mid_track();
    i_valid = 1;
    rst_async = 1;
    #1;
    n_vec++;
    if ({o_state, o_fe_enable, o_fe_subsamp, o_locked, o_err, o_avg_valid,
         o_fe_valid} !== '0 || o_fe_pipe_lat !== '0 || o_avg_value !== '0) begin
      n_err++;
      $display("FAIL async_reset state=%0d en=%b lk=%b avg=%0d exp=0",
               o_state, o_fe_enable, o_locked, o_avg_value);
    end
    #1;
    rst_async = 0;
    i_valid = 0;
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    i_timeout = 16'd50;
    i_start = 1;
    tick();
    i_start = 0;
    wait_acq(20);
    n = 0;
    while (o_state === 3'd2 && n < 200) begin
      n++;
      tick();
    end
    n_vec++;
    if (n != 50) begin
      n_err++;
      $display("FAIL wd_cycles got=%0d exp=50", n);
    end
    n_vec++;
    if (o_state !== 3'd4 || o_fe_enable !== 1'b0 || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL wd_err state=%0d en=%b err=%b exp=4/0/1",
               o_state, o_fe_enable, o_err);
    end
    i_start = 1;
    tick();
    i_start = 0;
    tick();
    n_vec++;
    if (o_state !== 3'd4 || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_start state=%0d err=%b exp=4/1", o_state, o_err);
    end
    i_stop = 1;
    tick();
    i_stop = 0;
    n_vec++;
    if (o_state !== 3'd0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_stop state=%0d err=%b exp=0/0", o_state, o_err);
    end
    i_timeout = '0;
  endtask

  task automatic test_back_to_back();
    int vals[8] = '{1, 2, 3, 4, -1, -1, -1, -2};
    do_reset();
    i_pipe_lat = 10'd3;
    i_start = 1;
    i_stop = 1;
    tick();
    i_start = 0;
    i_stop = 0;
    tick();
    n_vec++;
    if (o_state !== 3'd0 || o_fe_enable !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop state=%0d en=%b exp=0/0", o_state, o_fe_enable);
    end
    i_pipe_lat = '0;
    i_start = 1;
    tick();
    i_start = 0;
    wait_acq(20);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp_q.push_back(floor_avg(1 + 2 + 3 + 4));
      if (i == 7) exp_q.push_back(floor_avg(-5));
      i_fo_valid = 1;
      i_fo_value = NBW_FO'(vals[i]);
      tick();
    end
    i_fo_valid = 0;
    tick();
    tick();
    n_vec++;
    if (o_state !== 3'd2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b state=%0d pending=%0d exp=2/0", o_state, exp_q.size());
    end
    send_valid(50);
    send_valid(50);
    send_valid(50);
    i_fo_valid = 1;
    i_fo_value = 15'd50;
    i_stop = 1;
    tick();
    i_fo_valid = 0;
    i_stop = 0;
    n_vec++;
    if (o_state !== 3'd0 || o_fe_enable !== 1'b0) begin
      n_err++;
      $display("FAIL stop_last state=%0d en=%b exp=0/0", o_state, o_fe_enable);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (o_avg_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stop_suppress got=%b exp=0", o_avg_valid);
      end
      tick();
    end
    i_start = 1;
    tick();
    i_start = 0;
    wait_acq(20);
    send_block(4, 5, 6, 7);
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL restart_avg pending=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_warm();
    test_average();
    test_lock();
    test_reset_mid_track();
    test_watchdog();
    test_back_to_back();
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
